infix2postfix_stream: RTL and testbench

//  Sequential shunting-yard converter: takes an infix expression as a byte stream
//  (digits, '+', '*', '-' sign, '(', ')', ' ') and emits the space-separated postfix

---
 rtl/infix2postfix_stream.sv | 324 ++++++++++++++++++++++++++++++++
 tb/tb_infix2postfix_stream.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/infix2postfix_stream.sv
// Streaming shunting-yard converter: infix characters in, space-separated
// postfix characters out, each expression closed by an 8'h00 terminator.
// A single output register plus a one-byte pending slot lets a token be
// preceded by its separator space without stalling the state machine.
module infix2postfix_stream #(
    parameter int STACK_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_char,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_char,
    output logic       out_last,
    output logic       error,
    output logic       busy
);
    localparam int SPW = $clog2(STACK_DEPTH + 1);
    localparam int IW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_POP, S_FLUSH, S_TERM, S_DRAIN} state_t;
    typedef enum logic [1:0] {OP_PLUS, OP_MUL, OP_LPAREN, OP_RPAREN} op_t;

    state_t         state, next_state;
    op_t            stack [STACK_DEPTH];
    logic [SPW-1:0] sp;
    logic [IW-1:0]  wr_idx, top_idx;
    op_t            top, in_op, cur_op, n_cur_op, push_val;
    logic           stack_full, stack_empty, top_is_op;

    logic           expect_operand, in_num, need_sep, saw_digit, last_seen;
    logic           e_expect, e_in_num, e_need_sep, e_saw;
    logic           n_expect, n_in_num, n_need_sep, n_saw, n_last;
    logic           pend_valid;
    logic [7:0]     pend_char;
    logic           out_free, can_emit, accept, is_digit;
    logic           emit1, emit2, emit_last;
    logic [7:0]     emit_c1, emit_c2;
    logic           push, pop, clear_stack, set_err, clr_err, bad, bad_final;

    function automatic logic [7:0] op_char(input op_t op);
        return (op == OP_MUL) ? "*" : "+";
    endfunction

    // '*' binds tighter than '+'; equal precedence pops too (left-assoc)
    function automatic logic prec_ge(input op_t stacked, input op_t incoming);
        return (stacked == OP_MUL) || (incoming == OP_PLUS);
    endfunction

    assign wr_idx      = sp[IW-1:0];
    assign top_idx     = wr_idx - IW'(1);
    assign top         = stack[top_idx];
    assign stack_full  = (sp == SPW'(STACK_DEPTH));
    assign stack_empty = (sp == '0);
    assign top_is_op   = !stack_empty && (top == OP_PLUS || top == OP_MUL);
    assign in_op       = (in_char == "*") ? OP_MUL : OP_PLUS;
    assign is_digit    = (in_char >= "0") && (in_char <= "9");

    assign out_free = !out_valid || out_ready;
    assign can_emit = out_free && !pend_valid;
    assign in_ready = !rst && ((((state == S_IDLE) || (state == S_RUN)) && can_emit) ||
                               (state == S_DRAIN));
    assign accept   = in_valid && in_ready;
    assign busy     = (state != S_IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // Next-state, token handling, stack control and output byte selection
    always_comb begin
        e_expect   = (state == S_IDLE) ? 1'b1 : expect_operand;
        e_in_num   = (state == S_IDLE) ? 1'b0 : in_num;
        e_need_sep = (state == S_IDLE) ? 1'b0 : need_sep;
        e_saw      = (state == S_IDLE) ? 1'b0 : saw_digit;
        next_state = state;
        n_expect   = e_expect;
        n_in_num   = e_in_num;
        n_need_sep = e_need_sep;
        n_saw      = e_saw;
        n_cur_op   = cur_op;
        n_last     = last_seen;
        emit1      = 1'b0;
        emit2      = 1'b0;
        emit_c1    = 8'h00;
        emit_c2    = 8'h00;
        emit_last  = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        push_val   = OP_PLUS;
        clear_stack = 1'b0;
        set_err    = 1'b0;
        clr_err    = 1'b0;
        bad        = 1'b0;
        bad_final  = 1'b0;
        case (state)
            S_IDLE, S_RUN: begin
                if (accept) begin
                    if (state == S_IDLE) begin
                        clr_err    = 1'b1;
                        next_state = S_RUN;
                    end
                    n_last    = in_last;
                    bad_final = in_last;
                    if (is_digit) begin
                        if (!e_expect && !e_in_num) begin
                            bad = 1'b1;
                        end else begin
                            n_saw      = 1'b1;
                            n_expect   = 1'b0;
                            n_in_num   = 1'b1;
                            n_need_sep = 1'b1;
                            emit1      = 1'b1;
                            if (!e_in_num && e_need_sep) begin
                                emit_c1 = " ";
                                emit2   = 1'b1;
                                emit_c2 = in_char;
                            end else begin
                                emit_c1 = in_char;
                            end
                        end
                    end else if (in_char == " ") begin
                        if (!e_expect) n_in_num = 1'b0;
                    end else if (in_char == "-") begin
                        if (!e_expect || e_in_num) begin
                            bad = 1'b1;
                        end else begin
                            n_in_num   = 1'b1;
                            n_need_sep = 1'b1;
                            emit1      = 1'b1;
                            if (e_need_sep) begin
                                emit_c1 = " ";
                                emit2   = 1'b1;
                                emit_c2 = "-";
                            end else begin
                                emit_c1 = "-";
                            end
                        end
                    end else if (in_char == "+" || in_char == "*") begin
                        if (e_expect) begin
                            bad = 1'b1;
                        end else begin
                            n_in_num = 1'b0;
                            n_expect = 1'b1;
                            if (top_is_op && prec_ge(top, in_op)) begin
                                n_cur_op   = in_op;
                                next_state = S_POP;
                            end else if (stack_full) begin
                                bad = 1'b1;
                            end else begin
                                push     = 1'b1;
                                push_val = in_op;
                            end
                        end
                    end else if (in_char == "(") begin
                        if (!e_expect || e_in_num || stack_full) begin
                            bad = 1'b1;
                        end else begin
                            push     = 1'b1;
                            push_val = OP_LPAREN;
                        end
                    end else if (in_char == ")") begin
                        if (e_expect || stack_empty) begin
                            bad = 1'b1;
                        end else begin
                            n_in_num = 1'b0;
                            if (top == OP_LPAREN) begin
                                pop = 1'b1;
                            end else begin
                                n_cur_op   = OP_RPAREN;
                                next_state = S_POP;
                            end
                        end
                    end else begin
                        bad = 1'b1;
                    end
                    if (!bad && in_last) begin
                        if (n_expect || !n_saw) bad = 1'b1;
                        else if (next_state != S_POP) next_state = S_FLUSH;
                    end
                end
            end
            S_POP: begin
                bad_final = last_seen;
                if (can_emit) begin
                    if (cur_op == OP_RPAREN) begin
                        if (stack_empty) begin
                            bad = 1'b1;
                        end else if (top == OP_LPAREN) begin
                            pop        = 1'b1;
                            next_state = last_seen ? S_FLUSH : S_RUN;
                        end else begin
                            pop     = 1'b1;
                            emit1   = 1'b1;
                            emit_c1 = " ";
                            emit2   = 1'b1;
                            emit_c2 = op_char(top);
                        end
                    end else if (top_is_op && prec_ge(top, cur_op)) begin
                        pop     = 1'b1;
                        emit1   = 1'b1;
                        emit_c1 = " ";
                        emit2   = 1'b1;
                        emit_c2 = op_char(top);
                    end else if (stack_full) begin
                        bad = 1'b1;
                    end else begin
                        push       = 1'b1;
                        push_val   = cur_op;
                        next_state = S_RUN;
                    end
                end
            end
            S_FLUSH: begin
                bad_final = 1'b1;
                if (can_emit) begin
                    if (stack_empty) begin
                        next_state = S_TERM;
                    end else if (top == OP_LPAREN) begin
                        bad = 1'b1;
                    end else begin
                        pop     = 1'b1;
                        emit1   = 1'b1;
                        emit_c1 = " ";
                        emit2   = 1'b1;
                        emit_c2 = op_char(top);
                    end
                end
            end
            S_TERM: begin
                clear_stack = 1'b1;
                if (out_valid && out_last) begin
                    if (out_ready) next_state = S_IDLE;
                end else if (can_emit) begin
                    emit1     = 1'b1;
                    emit_c1   = 8'h00;
                    emit_last = 1'b1;
                end
            end
            S_DRAIN: begin
                if (accept && in_last) next_state = S_TERM;
            end
            default: next_state = S_IDLE;
        endcase
        if (bad) begin
            emit1       = 1'b0;
            emit2       = 1'b0;
            push        = 1'b0;
            pop         = 1'b0;
            set_err     = 1'b1;
            clear_stack = 1'b1;
            next_state  = bad_final ? S_TERM : S_DRAIN;
        end
    end

    // Output register with one-byte pending slot for the separator case
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_char   <= 8'h00;
            out_last   <= 1'b0;
            pend_valid <= 1'b0;
            pend_char  <= 8'h00;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            if (pend_valid && out_free) begin
                out_valid  <= 1'b1;
                out_char   <= pend_char;
                pend_valid <= 1'b0;
            end
            if (emit1) begin
                out_valid <= 1'b1;
                out_char  <= emit_c1;
                out_last  <= emit_last;
            end
            if (emit2) begin
                pend_valid <= 1'b1;
                pend_char  <= emit_c2;
            end
        end
    end

    // Operator stack ('+', '*', '(')
    always_ff @(posedge clk) begin
        if (rst || clear_stack) begin
            sp <= '0;
        end else if (push) begin
            stack[wr_idx] <= push_val;
            sp            <= sp + SPW'(1);
        end else if (pop) begin
            sp <= sp - SPW'(1);
        end
    end

    // Per-expression parse context and sticky error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            expect_operand <= 1'b1;
            in_num         <= 1'b0;
            need_sep       <= 1'b0;
            saw_digit      <= 1'b0;
            last_seen      <= 1'b0;
            cur_op         <= OP_PLUS;
            error          <= 1'b0;
        end else begin
            expect_operand <= n_expect;
            in_num         <= n_in_num;
            need_sep       <= n_need_sep;
            saw_digit      <= n_saw;
            last_seen      <= n_last;
            cur_op         <= n_cur_op;
            if (clr_err) error <= 1'b0;
            if (set_err) error <= 1'b1;
        end
    end
endmodule

// File: tb/tb_infix2postfix_stream.sv
// Directed bench for infix2postfix_stream: drives expressions character by
// character and compares the collected postfix bytes with hand-derived strings.
module tb_infix2postfix_stream;
    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_char;
    logic       in_last;
    logic       out_ready;
    logic       use_small;

    logic       in_valid_a, in_ready_a, out_valid_a, out_last_a, error_a, busy_a;
    logic [7:0] out_char_a;
    logic       in_valid_b, in_ready_b, out_valid_b, out_last_b, error_b, busy_b;
    logic [7:0] out_char_b;

    logic       mon_in_ready, mon_out_valid, mon_out_last, mon_error, mon_busy;
    logic [7:0] mon_out_char;

    int check_count;
    int pass_count;

    logic [127:0] got;
    logic         got_term;
    logic         err_at_term;

    assign in_valid_a = in_valid && !use_small;
    assign in_valid_b = in_valid && use_small;

    assign mon_in_ready  = use_small ? in_ready_b  : in_ready_a;
    assign mon_out_valid = use_small ? out_valid_b : out_valid_a;
    assign mon_out_char  = use_small ? out_char_b  : out_char_a;
    assign mon_out_last  = use_small ? out_last_b  : out_last_a;
    assign mon_error     = use_small ? error_b     : error_a;
    assign mon_busy      = use_small ? busy_b      : busy_a;

    infix2postfix_stream dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .in_char(in_char), .in_last(in_last),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_char(out_char_a),
        .out_last(out_last_a), .error(error_a), .busy(busy_a)
    );

    infix2postfix_stream #(.STACK_DEPTH(2)) dut_small (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_char(in_char), .in_last(in_last),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_char(out_char_b),
        .out_last(out_last_b), .error(error_b), .busy(busy_b)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        check_count++;
        if (observed === expected) pass_count++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input string expr, input bit stall_mode,
                                 output logic [127:0] bytes_out, output logic term_seen,
                                 output logic term_err);
        int         idx;
        bit         held;
        bit         done;
        logic [7:0] held_char;
        bytes_out = '0;
        term_seen = 1'b0;
        term_err  = 1'b0;
        idx       = 0;
        held      = 1'b0;
        done      = 1'b0;
        held_char = 8'h00;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            @(negedge clk);
            if (held) begin
                checkOutput("stall_valid", 128'(mon_out_valid), 128'(1));
                checkOutput("stall_char", 128'(mon_out_char), 128'(held_char));
                held = 1'b0;
            end
            in_valid  = (idx < expr.len()) && (!stall_mode || (cyc % 3 != 2));
            in_char   = (idx < expr.len()) ? expr[idx] : 8'h00;
            in_last   = (idx == expr.len() - 1);
            out_ready = !stall_mode || (cyc % 2 == 0);
            #1;
            if (mon_out_valid && !out_ready) begin
                held      = 1'b1;
                held_char = mon_out_char;
            end
            if (in_valid && mon_in_ready) idx++;
            if (mon_out_valid && out_ready) begin
                if (mon_out_last) begin
                    checkOutput("term_char", 128'(mon_out_char), 128'(0));
                    term_seen = 1'b1;
                    term_err  = mon_error;
                    done      = 1'b1;
                end else begin
                    bytes_out = {bytes_out[119:0], mon_out_char};
                end
            end
            @(posedge clk);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic runCase(input string tag, input string expr, input bit stall_mode,
                           input logic [127:0] exp_bytes, input logic exp_err);
        applyStimulus(expr, stall_mode, got, got_term, err_at_term);
        checkOutput({tag, "_bytes"}, got, exp_bytes);
        checkOutput({tag, "_term"}, 128'(got_term), 128'(1));
        checkOutput({tag, "_error"}, 128'(err_at_term), 128'(exp_err));
    endtask

    // Directed sequence
    initial begin
        check_count = 0;
        pass_count  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_char   = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b1;
        use_small = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_out_valid", 128'(mon_out_valid), 128'(0));
        checkOutput("rst_out_char", 128'(mon_out_char), 128'(0));
        checkOutput("rst_out_last", 128'(mon_out_last), 128'(0));
        checkOutput("rst_error", 128'(mon_error), 128'(0));
        checkOutput("rst_busy", 128'(mon_busy), 128'(0));
        checkOutput("rst_in_ready", 128'(mon_in_ready), 128'(0));
        rst = 1'b0;
        @(negedge clk);
        checkOutput("in_ready_after_rst", 128'(mon_in_ready), 128'(1));

        runCase("prec", "1+2*3", 1'b0, "1 2 3 * +", 1'b0);
        runCase("paren_sign", "(12+3)*-4", 1'b0, "12 3 + -4 *", 1'b0);
        runCase("pop_equal", "2*3+4", 1'b0, "2 3 * 4 +", 1'b0);
        runCase("stalled", "1+2*3", 1'b1, "1 2 3 * +", 1'b0);
        runCase("open_paren", "(1+2", 1'b0, "1 2 +", 1'b1);
        checkOutput("error_sticky", 128'(mon_error), 128'(1));
        checkOutput("idle_after_term", 128'(mon_busy), 128'(0));
        runCase("recover", "7", 1'b0, "7", 1'b0);
        runCase("spaces", "10 + 2", 1'b0, "10 2 +", 1'b0);
        runCase("trailing_op", "3+", 1'b0, "3", 1'b1);

        use_small = 1'b1;
        runCase("overflow", "(((1)))", 1'b0, 128'h0, 1'b1);
        runCase("small_ok", "1*2+3", 1'b0, "1 2 * 3 +", 1'b0);
        use_small = 1'b0;

        // Abort an expression partway through with reset
        @(negedge clk);
        in_valid  = 1'b1;
        in_char   = "1";
        in_last   = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_char = "+";
        checkOutput("mid_busy", 128'(mon_busy), 128'(1));
        checkOutput("mid_out_valid", 128'(mon_out_valid), 128'(1));
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("abort_out_valid", 128'(mon_out_valid), 128'(0));
        checkOutput("abort_busy", 128'(mon_busy), 128'(0));
        rst       = 1'b0;
        out_ready = 1'b1;
        runCase("after_abort", "1+2*3", 1'b0, "1 2 3 * +", 1'b0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end
endmodule
